// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: op classes, MIPS opcode/funct constants, FSM states and the encoder.
package instr_encoder_loader_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLT = 4'd4,
        OP_BEQ = 4'd5,
        OP_LW  = 4'd6,
        OP_SW  = 4'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_PAD,
        S_DONE
    } state_e;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    function automatic logic [31:0] encode(input op_e op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [15:0] imm);
        logic [5:0] funct;
        funct = op == OP_ADD ? FN_ADD :
                op == OP_SUB ? FN_SUB :
                op == OP_AND ? FN_AND :
                op == OP_OR  ? FN_OR  : FN_SLT;
        return op == OP_BEQ ? {OPC_BEQ, rs, rt, imm} :
               op == OP_LW  ? {OPC_LW, rs, rt, imm} :
               op == OP_SW  ? {OPC_SW, rs, rt, imm} :
                              {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
    endfunction

endpackage

// File: rtl/instr_encoder_loader_sync_fifo.sv
// sync_fifo: power-of-2 depth FIFO with registered full/empty and simultaneous push/pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q, do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;
    assign cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign dout_o  = mem_q[rp_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wp_q    <= do_push ? wp_q + 1'b1 : wp_q;
            rp_q    <= do_pop ? rp_q + 1'b1 : rp_q;
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wp_q] <= din_i;
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic MIPS ops and streams them into instruction memory.
// Define NOP_PAD_EN to append NOP_PAD zero words after the last real instruction.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BASE_ADDR  = 0,
    parameter int NOP_PAD    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   instr_count,
    output logic              illegal_err,
    output logic              wrap_err
);
    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              ill_q, ill_d, wrap_q, wrap_d;
    logic              fifo_full, fifo_empty, fifo_we, pad_we, accept, push, fire;
    logic [31:0]       head;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (encode(op_e'(in_op), in_rs, in_rt, in_rd, in_imm)),
        .pop_i   (fifo_we && imem_ready),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready    = state_q == S_LOAD && !fifo_full;
    assign accept      = in_valid && in_ready;
    assign push        = accept && !in_op[3];
    assign fifo_we     = !fifo_empty && (state_q == S_LOAD || state_q == S_DRAIN);
    assign pad_we      = state_q == S_PAD;
    assign imem_we     = fifo_we || pad_we;
    assign fire        = imem_we && imem_ready;
    assign imem_wdata  = fifo_we ? head : 32'h0;
    assign imem_addr   = addr_q;
    assign busy        = state_q == S_LOAD || state_q == S_DRAIN || state_q == S_PAD;
    assign done        = state_q == S_DONE;
    assign instr_count = cnt_q;
    assign illegal_err = ill_q;
    assign wrap_err    = wrap_q;

`ifdef NOP_PAD_EN
    localparam int PAD_W = $clog2(NOP_PAD + 1);
    logic [PAD_W-1:0] pad_q, pad_d;
    logic             pad_last;
    assign pad_last = pad_q == PAD_W'(NOP_PAD - 1);
    assign pad_d    = !pad_we ? '0 : fire ? pad_q + 1'b1 : pad_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pad_q <= '0;
        else pad_q <= pad_d;
    end
`else
    logic pad_last;
    assign pad_last = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ill_d   = ill_q;
        wrap_d  = wrap_q;
        if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            state_d = S_LOAD;
            addr_d  = ADDR_W'(BASE_ADDR);
            cnt_d   = '0;
            ill_d   = 1'b0;
            wrap_d  = 1'b0;
        end else begin
            ill_d = ill_q || (accept && in_op[3]);
            if (fire) begin
                addr_d = addr_q + 1'b1;
                wrap_d = wrap_q || &addr_q;
                cnt_d  = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
            end
            if (state_q == S_LOAD && accept && in_last) state_d = S_DRAIN;
`ifdef NOP_PAD_EN
            if (state_q == S_DRAIN && fifo_empty) state_d = S_PAD;
`else
            if (state_q == S_DRAIN && fifo_empty) state_d = S_DONE;
`endif
            if (pad_we && fire && pad_last) state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= ADDR_W'(BASE_ADDR);
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            wrap_q  <= wrap_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, backpressure, illegal ops, wrap and async reset.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_op = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [15:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        imem_ready = 1'b1;

    logic        in_ready, imem_we, busy, done, illegal_err, wrap_err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  instr_count;

    logic        w_in_ready, w_we, w_busy, w_done, w_ill, w_wrap;
    logic [1:0]  w_addr;
    logic [31:0] w_wdata;
    logic [2:0]  w_count;

    int errors = 0;
    int checks = 0;
    int wn = 0;
    int wwn = 0;
    logic [7:0]  wa [32];
    logic [31:0] wd [32];
    logic [1:0]  w_last_addr;

    always #5 clk = ~clk;

    instr_encoder_loader u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .instr_count(instr_count),
        .illegal_err(illegal_err), .wrap_err(wrap_err)
    );

    instr_encoder_loader #(.ADDR_W(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(w_we), .imem_ready(imem_ready), .imem_addr(w_addr),
        .imem_wdata(w_wdata), .busy(w_busy), .done(w_done), .instr_count(w_count),
        .illegal_err(w_ill), .wrap_err(w_wrap)
    );

    always @(negedge clk) begin
        if (imem_we && imem_ready && wn < 32) begin
            wa[wn] <= imem_addr;
            wd[wn] <= imem_wdata;
            wn <= wn + 1;
        end
        if (w_we && imem_ready) begin
            w_last_addr <= w_addr;
            wwn <= wwn + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        wn = 0;
        wwn = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_last = last;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) begin
            errors++;
            $error("FAIL send_timeout: in_ready never rose for op %0d", op);
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = done;
        end
        #1;
        if (!ok) begin
            errors++;
            $error("FAIL done_timeout: done never rose");
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, imem_we, 0);
        chk({tag, "_addr"}, imem_addr, 0);
        chk({tag, "_wdata"}, imem_wdata, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_count"}, instr_count, 0);
        chk({tag, "_ill"}, illegal_err, 0);
        chk({tag, "_wrap"}, wrap_err, 0);
    endtask

    logic [31:0] seq_data [5] = '{32'h00221822, 32'h0022202A, 32'h8C050008, 32'hAC05000C, 32'h1022FFFF};
    logic [31:0] bp_data  [6] = '{32'h00220820, 32'h00221020, 32'h00221820,
                                  32'h00222020, 32'h00222820, 32'h00223020};

    initial begin
        repeat (3) step();
        chk_reset("rst");
        rst_n = 1'b1;
        step();

        // single ADD
        do_start();
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        wait_done();
        chk("add_wn", wn, 1);
        chk("add_addr", wa[0], 8'h00);
        chk("add_data", wd[0], 32'h00221820);
        chk("add_done", done, 1);
        chk("add_busy", busy, 0);
        chk("add_count", instr_count, 1);

        // mixed sequence; the ADDR_W=2 instance wraps on its fifth word
        do_start();
        chk("seq_start_count", instr_count, 0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(4'd4, 5'd1, 5'd2, 5'd4, 16'h0, 1'b0);
        send(4'd6, 5'd0, 5'd5, 5'd0, 16'd8, 1'b0);
        send(4'd7, 5'd0, 5'd5, 5'd0, 16'd12, 1'b0);
        send(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b1);
        wait_done();
        chk("seq_wn", wn, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("seq_addr%0d", i), wa[i], i);
            chk($sformatf("seq_data%0d", i), wd[i], seq_data[i]);
        end
        chk("seq_count", instr_count, 5);
        chk("seq_wrap_clear", wrap_err, 0);
        chk("wrap_last_addr", w_last_addr, 0);
        chk("wrap_err", w_wrap, 1);
        chk("wrap_count_sat", w_count, 4);
        chk("wrap_writes", wwn, 5);

        // backpressure: memory stalls while six ops are offered
        imem_ready = 1'b0;
        do_start();
        for (int k = 0; k < 4; k++) send(4'd0, 5'd1, 5'd2, 5'(k + 1), 16'h0, 1'b0);
        in_valid = 1'b1;
        in_op = 4'd0; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_we", imem_we, 1);
            chk("bp_addr", imem_addr, 0);
            chk("bp_data", imem_wdata, 32'h00220820);
        end
        step();
        imem_ready = 1'b1;
        send(4'd0, 5'd1, 5'd2, 5'd5, 16'h0, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd6, 16'h0, 1'b1);
        wait_done();
        chk("bp_wn", wn, 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_addr%0d", i), wa[i], i);
            chk($sformatf("bp_data%0d", i), wd[i], bp_data[i]);
        end
        chk("bp_count", instr_count, 6);

        // illegal op in the middle of a session
        do_start();
        chk("ill_cleared", illegal_err, 0);
        send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(4'd9, 5'd7, 5'd7, 5'd7, 16'h1234, 1'b0);
        send(4'd0, 5'd1, 5'd2, 5'd4, 16'h0, 1'b1);
        wait_done();
        chk("ill_err", illegal_err, 1);
        chk("ill_wn", wn, 2);
        chk("ill_addr0", wa[0], 0);
        chk("ill_addr1", wa[1], 1);
        chk("ill_data0", wd[0], 32'h00221820);
        chk("ill_data1", wd[1], 32'h00222020);
        chk("ill_count", instr_count, 2);

        // asynchronous reset while draining
        imem_ready = 1'b0;
        do_start();
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        step();
        chk("drain_busy", busy, 1);
        chk("drain_we", imem_we, 1);
        chk("drain_data", imem_wdata, 32'h00221824);
        #2 rst_n = 1'b0;
        #1 chk_reset("arst");
        step();
        rst_n = 1'b1;
        imem_ready = 1'b1;
        step();
        do_start();
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 1'b1);
        wait_done();
        chk("rl_wn", wn, 1);
        chk("rl_addr", wa[0], 0);
        chk("rl_data", wd[0], 32'h00221825);
        chk("rl_count", instr_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL global_timeout: bench did not finish");
    end
endmodule
